// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage feeding the IF/ID pipeline register. Owns the program counter,
// issues word reads to a synchronous instruction memory (one-cycle read
// latency) and presents each returned word together with its PC + 4. A
// one-entry skid buffer absorbs downstream stalls; branch redirects squash
// any wrong-path fetch in flight or parked in the skid buffer.
//
// Optional feature macro: FETCH_HALT_EN
//   defined   : a delivered 32'hFFFF_FFFF word stops fetching until Reset.
//   undefined : 32'hFFFF_FFFF is an ordinary instruction, Out_Halted is 0.
//
// Ports
//   Clock            in   rising-edge clock
//   Reset            in   asynchronous, active-high reset
//   Enable           in   1 = IF/ID captures Out_* at this edge, 0 = stall
//   In_Branch        in   redirect request (sampled every edge)
//   In_BranchAddress in   redirect target, bits [1:0] forced to 00
//   Out_IMemReq      out  memory read request this cycle
//   Out_IMemAddr     out  byte address of the request (the PC register)
//   In_IMemData      in   read data, valid the cycle after a request
//   Out_Instruction  out  instruction presented downstream
//   Out_PCAdder      out  PC of the presented instruction + 4
//   Out_Valid        out  presented instruction is live
//   Out_Flush        out  squash strobe to IF/ID (mirrors In_Branch)
//   Out_Halted       out  fetch stopped on a HALT word
// ---------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Enable,
    input  logic        In_Branch,
    input  logic [31:0] In_BranchAddress,
    output logic        Out_IMemReq,
    output logic [31:0] Out_IMemAddr,
    input  logic [31:0] In_IMemData,
    output logic [31:0] Out_Instruction,
    output logic [31:0] Out_PCAdder,
    output logic        Out_Valid,
    output logic        Out_Flush,
    output logic        Out_Halted
);

    logic [31:0] pc;
    logic        resp_valid;
    logic [31:0] resp_pc;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic        halted;

    logic        pres_valid;
    logic [31:0] pres_instr;
    logic [31:0] pres_pc;
    logic        halt_now;
    logic        req;

    // The skid entry is always older than anything in flight, so it wins.
    always_comb begin
        pres_valid = 1'b0;
        pres_instr = 32'h0;
        pres_pc    = 32'h0;
        if (skid_valid) begin
            pres_valid = 1'b1;
            pres_instr = skid_instr;
            pres_pc    = skid_pc;
        end else if (resp_valid) begin
            pres_valid = 1'b1;
            pres_instr = In_IMemData;
            pres_pc    = resp_pc;
        end
    end

    // A redirect squashes whatever is being presented in the same cycle.
    assign Out_Valid       = pres_valid & ~In_Branch;
    assign Out_Instruction = Out_Valid ? pres_instr : 32'h0;
    assign Out_PCAdder     = Out_Valid ? (pres_pc + 32'd4) : 32'h0;
    assign Out_Flush       = In_Branch;
    assign Out_IMemAddr    = pc;
    assign Out_Halted      = halted;

`ifdef FETCH_HALT_EN
    assign halt_now = Out_Valid & Enable & (Out_Instruction == 32'hFFFF_FFFF);
`else
    assign halt_now = 1'b0;
`endif

    // Requests only issue while the consumer is capturing, which is what
    // keeps a single skid entry sufficient.
    assign req         = Enable & ~In_Branch & ~halted & ~halt_now & ~Reset;
    assign Out_IMemReq = req;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pc         <= RESET_PC;
            resp_valid <= 1'b0;
            resp_pc    <= 32'h0;
            skid_valid <= 1'b0;
            skid_instr <= 32'h0;
            skid_pc    <= 32'h0;
            halted     <= 1'b0;
        end else if (In_Branch) begin
            pc         <= In_BranchAddress & 32'hFFFF_FFFC;
            resp_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            resp_valid <= req;
            if (req) begin
                resp_pc <= pc;
                pc      <= pc + 32'd4;
            end
            if (Enable) begin
                skid_valid <= 1'b0;
            end else if (resp_valid && !skid_valid) begin
                // Memory data is only valid this one cycle; park it.
                skid_valid <= 1'b1;
                skid_instr <= In_IMemData;
                skid_pc    <= resp_pc;
            end
            if (halt_now) begin
                halted <= 1'b1;
            end
        end
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage directly upstream of the IF/ID pipeline register. Owns the program counter, issues word reads to a synchronous instruction memory with one-cycle read latency, and pairs each returned word with its PC+4. Absorbs downstream stalls with a one-entry skid buffer and applies branch redirects, squashing wrong-path fetches. Its instruction, PC+4 and flush outputs feed the IF/ID register's instruction, PC-adder and flush inputs.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- Enable  in  1  consumer capture strobe; 1 = IF/ID latches Out_* at this edge, 0 = stall.
- In_Branch  in  1  redirect request from decode; sampled every edge regardless of Enable.
- In_BranchAddress  in  32  redirect target; bits [1:0] ignored, treated as 00.
- Out_IMemReq  out  1  read request this cycle.
- Out_IMemAddr  out  32  byte address of the request; equals the PC register.
- In_IMemData  in  32  read data, valid the cycle after an accepted request.
- Out_Instruction  out  32  instruction presented downstream.
- Out_PCAdder  out  32  PC of the presented instruction + 4.
- Out_Valid  out  1  Out_Instruction/Out_PCAdder hold a live instruction.
- Out_Flush  out  1  squash strobe to IF/ID.
- Out_Halted  out  1  fetch stopped on a HALT word (see Configuration).

## Operation
- State: PC (32), resp_valid and resp_pc (response in flight), skid_valid, skid_instr and skid_pc, halted.
- Request: Out_IMemReq = Enable & ~In_Branch & ~halted & ~halt_now. On request, resp_pc <= PC, PC <= PC + 4, resp_valid <= 1; otherwise resp_valid <= 0.
- Presentation: if skid_valid, present skid entry; else if resp_valid, present In_IMemData with resp_pc; else Out_Valid = 0. Out_PCAdder = presented PC + 4, modulo 2^32.
- Stall: Enable = 0 with resp_valid = 1 and skid empty -> response written into skid. PC holds; no request issued.
- Drain: Enable = 1 with skid_valid -> skid consumed and cleared at that edge. A new request may issue in the same cycle.
- Redirect: In_Branch = 1 -> at the edge PC <= {In_BranchAddress[31:2], 2'b00}, skid cleared, resp_valid <= 0. In the same cycle, Out_Flush = 1 combinationally, Out_Valid = 0, and no request issues.
- Out_Flush = In_Branch; it is high for exactly the cycles In_Branch is high.
- Priority: Reset > In_Branch > halt > stall/normal.
- Address arithmetic wraps: PC 32'hFFFF_FFFC advances to 0.

## Timing
- Reset values: PC = RESET_PC, Out_IMemReq = 0 while Reset high, Out_Valid = 0, Out_Instruction = 0, Out_PCAdder = 0, Out_Flush = 0, Out_Halted = 0, skid and in-flight cleared.
- First request is in the first cycle after Reset deasserts with Enable = 1, at RESET_PC.
- Fetch latency: request in cycle N; instruction valid at outputs in cycle N+1; captured by IF/ID at the end of N+1 if Enable = 1.
- Steady state (Enable = 1, no redirect) sustains one instruction per cycle.
- Redirect in cycle N: target requested in N+1, valid in N+2 (two bubbles).
- Stall never loses or duplicates an instruction; skid depth 1 is sufficient because requests require Enable = 1.
- Reset asserted mid-stall or mid-redirect: all state cleared; any data arriving on In_IMemData afterwards is ignored.

## Configuration
- FETCH_HALT_EN defined: halt_now = Out_Valid & Enable & (Out_Instruction == 32'hFFFF_FFFF). The HALT word is delivered downstream; at that edge halted <= 1 and no further requests are issued. Out_Halted = halted; only Reset clears it, and In_Branch does not. A redirect in the same cycle takes priority and halted stays 0.
- FETCH_HALT_EN undefined: halt_now = 0, Out_Halted tied 0, and 32'hFFFF_FFFF is an ordinary instruction.

## Test plan
- Reset with RESET_PC = 0, Enable = 1, memory word[i] = i -> addresses 0, 4, 8… on consecutive cycles; Out_Instruction 0, 1, 2… one cycle later with Out_PCAdder 4, 8, 12.
- Enable low for 3 cycles after fetching PC 8 -> PC 8 instruction held valid all 3 cycles and delivered once; PC 12 requested on the first Enable-high cycle; no gap or duplicate.
- In_Branch = 1 with target 0x103 while PC 0x20 is presented -> Out_Flush = 1 and Out_Valid = 0 that cycle; next request at 0x100; instruction from 0x20 never marked valid.
- Redirect during a stall with skid full -> skid discarded; next delivered instruction is the word at the target with Out_PCAdder = target + 4.
- Redirect to 0xFFFF_FFFC -> Out_PCAdder = 0; next request address 0.
- FETCH_HALT_EN: word at 0x10 = 32'hFFFF_FFFF -> HALT delivered, Out_Halted = 1, Out_IMemReq stays 0, no word from 0x14 ever valid; Reset clears Out_Halted.
